obr: RTL and testbench

Original Bits Receiver (OBR): the receive-side counterpart of the original-bits generator. It takes the serial decoded bit stream of one PHY frame, parses and checks the 24-bit SIGNAL field (RATE, reserved, LENGTH, parity, tail), then packs the following DATA bits into LENGTH payload bytes. It sits after the bit decoder and feeds the MAC-facing byte interface.

---
 rtl/obr.sv | 194 +++++++++++++++++++
 tb/tb_obr.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obr.sv
// Original Bits Receiver: parses the 24-bit SIGNAL field of a decoded PHY frame
// and packs the following DATA bits into LENGTH payload bytes, LSB first.
// Optional feature macro: OBR_SERVICE_STRIP_EN (drops the 16-bit SERVICE field
// ahead of the payload).
// The payload byte port is named do_byte because "do" is a reserved word.
module obr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        new_frame,
    input  logic        di,
    input  logic        di_vld,
    output logic [3:0]  sig_type,
    output logic [15:0] sig_len,
    output logic        sig_vld,
    output logic        sig_err,
    output logic [2:0]  err_code,
    output logic [7:0]  do_byte,
    output logic        do_vld,
    output logic        do_last,
    output logic        busy
);

    localparam int unsigned SIG_W   = 24;
    localparam int unsigned BIT_CW  = 5;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BYTE_CW = 12;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TYPE_W  = 4;
    localparam int unsigned ERR_W   = 3;
`ifdef OBR_SERVICE_STRIP_EN
    localparam int unsigned SVC_W   = 16;
`endif

    typedef enum logic [2:0] {
        IDLE,
        SIG,
`ifdef OBR_SERVICE_STRIP_EN
        SVC,
`endif
        PLD,
        DONE
    } state_t;

    state_t                 state, state_nx;
    logic [SIG_W-2:0]       sig_sr, sig_sr_nx;
    logic [BYTE_W-2:0]      byte_sr, byte_sr_nx;
    logic [BIT_CW-1:0]      bit_cnt, bit_cnt_nx;
    logic [BYTE_CW-1:0]     byte_cnt, byte_cnt_nx;
    logic [BYTE_CW-1:0]     byte_cnt_inc;
    logic [TYPE_W-1:0]      sig_type_nx;
    logic [LEN_W-1:0]       sig_len_nx;
    logic [ERR_W-1:0]       err_code_nx;
    logic [ERR_W-1:0]       sig_chk;
    logic [BYTE_W-1:0]      do_byte_nx;
    logic [SIG_W-1:0]       sig_word;
    logic [BYTE_W-1:0]      byte_word;
    logic                   sig_vld_nx, sig_err_nx, do_vld_nx, do_last_nx, busy_nx;

    // Complete SIGNAL word / payload byte including the bit arriving this cycle
    assign sig_word     = {di, sig_sr};
    assign byte_word    = {di, byte_sr};
    assign byte_cnt_inc = byte_cnt + BYTE_CW'(1);

    // SIGNAL checks: even parity, reserved/tail zero, legal RATE and LENGTH
    assign sig_chk[0] = ^sig_word[17:0];
    assign sig_chk[1] = sig_word[4] | (|sig_word[23:18]);
    assign sig_chk[2] = ~sig_word[3] | (sig_word[16:5] == 12'd0);

    // Next-state and next-output logic
    always_comb begin
        state_nx    = state;
        sig_sr_nx   = sig_sr;
        byte_sr_nx  = byte_sr;
        bit_cnt_nx  = bit_cnt;
        byte_cnt_nx = byte_cnt;
        sig_type_nx = sig_type;
        sig_len_nx  = sig_len;
        err_code_nx = err_code;
        do_byte_nx  = do_byte;
        busy_nx     = busy;
        sig_vld_nx  = 1'b0;
        sig_err_nx  = 1'b0;
        do_vld_nx   = 1'b0;
        do_last_nx  = 1'b0;

        if (new_frame) begin
            // Restart wins over everything, including a same-cycle di_vld
            state_nx    = SIG;
            bit_cnt_nx  = '0;
            byte_cnt_nx = '0;
            sig_type_nx = '0;
            sig_len_nx  = '0;
            err_code_nx = '0;
            busy_nx     = 1'b1;
        end else begin
            case (state)
                SIG: begin
                    if (di_vld) begin
                        if (bit_cnt == BIT_CW'(SIG_W - 1)) begin
                            bit_cnt_nx = '0;
                            if (sig_chk != '0) begin
                                err_code_nx = sig_chk;
                                sig_err_nx  = 1'b1;
                                busy_nx     = 1'b0;
                                state_nx    = IDLE;
                            end else begin
                                sig_type_nx = sig_word[3:0];
                                sig_len_nx  = LEN_W'(sig_word[16:5]);
                                sig_vld_nx  = 1'b1;
`ifdef OBR_SERVICE_STRIP_EN
                                state_nx    = SVC;
`else
                                state_nx    = PLD;
`endif
                            end
                        end else begin
                            sig_sr_nx[bit_cnt] = di;
                            bit_cnt_nx         = bit_cnt + BIT_CW'(1);
                        end
                    end
                end
`ifdef OBR_SERVICE_STRIP_EN
                SVC: begin
                    if (di_vld) begin
                        if (bit_cnt == BIT_CW'(SVC_W - 1)) begin
                            bit_cnt_nx = '0;
                            state_nx   = PLD;
                        end else begin
                            bit_cnt_nx = bit_cnt + BIT_CW'(1);
                        end
                    end
                end
`endif
                PLD: begin
                    if (di_vld) begin
                        if (bit_cnt[2:0] == 3'd7) begin
                            bit_cnt_nx  = '0;
                            do_byte_nx  = byte_word;
                            do_vld_nx   = 1'b1;
                            byte_cnt_nx = byte_cnt_inc;
                            if (byte_cnt_inc == sig_len[BYTE_CW-1:0]) begin
                                do_last_nx = 1'b1;
                                busy_nx    = 1'b0;
                                state_nx   = DONE;
                            end
                        end else begin
                            byte_sr_nx[bit_cnt[2:0]] = di;
                            bit_cnt_nx               = bit_cnt + BIT_CW'(1);
                        end
                    end
                end
                default: begin
                    // IDLE and DONE ignore di_vld
                end
            endcase
        end
    end

    // State and output registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sig_sr   <= '0;
            byte_sr  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sig_type <= '0;
            sig_len  <= '0;
            sig_vld  <= 1'b0;
            sig_err  <= 1'b0;
            err_code <= '0;
            do_byte  <= '0;
            do_vld   <= 1'b0;
            do_last  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            sig_sr   <= sig_sr_nx;
            byte_sr  <= byte_sr_nx;
            bit_cnt  <= bit_cnt_nx;
            byte_cnt <= byte_cnt_nx;
            sig_type <= sig_type_nx;
            sig_len  <= sig_len_nx;
            sig_vld  <= sig_vld_nx;
            sig_err  <= sig_err_nx;
            err_code <= err_code_nx;
            do_byte  <= do_byte_nx;
            do_vld   <= do_vld_nx;
            do_last  <= do_last_nx;
            busy     <= busy_nx;
        end
    end

endmodule

// File: tb/tb_obr.sv
// Directed self-checking bench for obr.
module tb_obr;

    logic        clk = 1'b0;
    logic        rst_n, new_frame, di, di_vld;
    logic [3:0]  sig_type;
    logic [15:0] sig_len;
    logic        sig_vld, sig_err;
    logic [2:0]  err_code;
    logic [7:0]  do_byte;
    logic        do_vld, do_last, busy;

    int checks   = 0;
    int failures = 0;

    // Event log collected away from the active edge
    int          cyc = 0;
    int          n_sig_vld, n_sig_err, n_last, n_last_bad;
    logic [7:0]  last_byte;
    logic [7:0]  bytes[$];
    int          byte_cyc[$];

    obr dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .new_frame(new_frame),
        .di       (di),
        .di_vld   (di_vld),
        .sig_type (sig_type),
        .sig_len  (sig_len),
        .sig_vld  (sig_vld),
        .sig_err  (sig_err),
        .err_code (err_code),
        .do_byte  (do_byte),
        .do_vld   (do_vld),
        .do_last  (do_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sig_vld) n_sig_vld++;
        if (sig_err) n_sig_err++;
        if (do_vld) begin
            bytes.push_back(do_byte);
            byte_cyc.push_back(cyc);
        end
        if (do_last) begin
            n_last++;
            last_byte = do_byte;
            if (!do_vld) n_last_bad++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        n_sig_vld = 0; n_sig_err = 0; n_last = 0; n_last_bad = 0;
        last_byte = 8'h00;
        bytes.delete();
        byte_cyc.delete();
    endtask

    function automatic int rand_gap();
        int g = 0;
        while ($urandom_range(0, 9) >= 3) g++;
        return g;
    endfunction

    // SIGNAL word: [3:0] RATE, [4] reserved, [16:5] LENGTH, [17] parity, [23:18] tail
    function automatic logic [23:0] mk_sig(input logic [3:0] rate, input logic [11:0] len,
                                           input logic rsv, input logic [5:0] tail,
                                           input logic flip);
        logic [23:0] w;
        w[3:0]   = rate;
        w[4]     = rsv;
        w[16:5]  = len;
        w[17]    = (^{len, rsv, rate}) ^ flip;
        w[23:18] = tail;
        return w;
    endfunction

    task automatic send_bit(input logic b, input int gap);
        di_vld = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        di = b; di_vld = 1'b1;
        @(posedge clk); #1;
        di_vld = 1'b0;
    endtask

    task automatic send_sig(input logic [23:0] w, input bit rnd);
        for (int i = 0; i < 24; i++) send_bit(w[i], rnd ? rand_gap() : 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        for (int i = 0; i < 8; i++) send_bit(b[i], rnd ? rand_gap() : 0);
    endtask

    task automatic send_service(input bit rnd);
`ifdef OBR_SERVICE_STRIP_EN
        send_byte(8'h96, rnd);
        send_byte(8'h69, rnd);
`else
        if (rnd) begin end
`endif
    endtask

    task automatic pulse_new_frame(input logic with_di);
        new_frame = 1'b1; di_vld = with_di; di = 1'b1;
        @(posedge clk); #1;
        new_frame = 1'b0; di_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; new_frame = 1'b0; di = 1'b0; di_vld = 1'b0;
        idle(3);
        checks++;
        if ({sig_type, sig_len, sig_vld, sig_err, err_code} !== 25'd0) begin
            failures++;
            $display("FAIL reset_sig: got type=%h len=%h vld=%b err=%b code=%b, want all 0",
                     sig_type, sig_len, sig_vld, sig_err, err_code);
        end
        checks++;
        if ({do_byte, do_vld, do_last, busy} !== 11'd0) begin
            failures++;
            $display("FAIL reset_do: got do=%h vld=%b last=%b busy=%b, want all 0",
                     do_byte, do_vld, do_last, busy);
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    // Valid frame: RATE arrival order 1,1,0,1 -> 4'b1011, LENGTH 3
    task automatic test_valid();
        clear_mon();
        pulse_new_frame(1'b0);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL valid_busy_rise: got %b want 1", busy); end
        send_sig(mk_sig(4'b1011, 12'd3, 1'b0, 6'd0, 1'b0), 1'b0);
        checks++;
        if (sig_vld !== 1'b1) begin failures++; $display("FAIL valid_sig_vld_timing: got %b want 1", sig_vld); end
        checks++;
        if (sig_type !== 4'hB || sig_len !== 16'd3) begin
            failures++;
            $display("FAIL valid_sig_fields: got type=%h len=%0d want type=b len=3", sig_type, sig_len);
        end
        send_service(1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        idle(1);
        checks++;
        if (bytes.size() != 3 || bytes[0] !== 8'hA5 || bytes[1] !== 8'h3C || bytes[2] !== 8'hFF) begin
            failures++;
            $display("FAIL valid_bytes: got count=%0d first=%h, want 3 bytes a5 3c ff",
                     bytes.size(), (bytes.size() > 0) ? bytes[0] : 8'hxx);
        end
        checks++;
        if (n_last != 1 || last_byte !== 8'hFF || n_last_bad != 0) begin
            failures++;
            $display("FAIL valid_last: got count=%0d byte=%h stray=%0d want 1 ff 0", n_last, last_byte, n_last_bad);
        end
        if (byte_cyc.size() == 3) begin
            checks++;
            if (byte_cyc[1] - byte_cyc[0] != 8 || byte_cyc[2] - byte_cyc[1] != 8) begin
                failures++;
                $display("FAIL valid_byte_spacing: got %0d,%0d want 8,8",
                         byte_cyc[1] - byte_cyc[0], byte_cyc[2] - byte_cyc[1]);
            end
        end
        checks++;
        if (busy !== 1'b0 || n_sig_vld != 1) begin
            failures++;
            $display("FAIL valid_busy_fall: got busy=%b sig_vld_count=%0d want 0 1", busy, n_sig_vld);
        end
        send_byte(8'hC3, 1'b0);
        send_byte(8'h0F, 1'b0);
        checks++;
        if (bytes.size() != 3) begin
            failures++;
            $display("FAIL valid_done_ignores: got %0d bytes want 3", bytes.size());
        end
    endtask

    task automatic test_err(input string name, input logic [23:0] w, input logic [2:0] exp_code);
        clear_mon();
        pulse_new_frame(1'b0);
        send_sig(w, 1'b0);
        checks++;
        if (sig_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_sig_err: got err=%b busy=%b want 1 0", name, sig_err, busy);
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        checks++;
        if (err_code !== exp_code) begin
            failures++;
            $display("FAIL %s_err_code: got %b want %b", name, err_code, exp_code);
        end
        checks++;
        if (n_sig_err != 1 || n_sig_vld != 0 || bytes.size() != 0) begin
            failures++;
            $display("FAIL %s_events: got err=%0d vld=%0d bytes=%0d want 1 0 0",
                     name, n_sig_err, n_sig_vld, bytes.size());
        end
    endtask

    task automatic test_parity();
        test_err("parity", mk_sig(4'b1011, 12'd3, 1'b0, 6'd0, 1'b1), 3'b001);
    endtask

    // Reserved bit and tail bit 20 set, parity kept even
    task automatic test_reserved();
        test_err("reserved", mk_sig(4'b1011, 12'd3, 1'b1, 6'b000100, 1'b0), 3'b010);
    endtask

    task automatic test_rate_len();
        test_err("rate_len", mk_sig(4'b0011, 12'd0, 1'b0, 6'd0, 1'b0), 3'b100);
    endtask

    // Abort mid-payload; restart pulse collides with a valid bit which must be dropped
    task automatic test_abort();
        clear_mon();
        pulse_new_frame(1'b0);
        send_sig(mk_sig(4'b1011, 12'd3, 1'b0, 6'd0, 1'b0), 1'b0);
        send_service(1'b0);
        send_byte(8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        pulse_new_frame(1'b1);
        checks++;
        if (busy !== 1'b1 || sig_len !== 16'd0) begin
            failures++;
            $display("FAIL abort_restart: got busy=%b len=%0d want 1 0", busy, sig_len);
        end
        send_sig(mk_sig(4'b1011, 12'd1, 1'b0, 6'd0, 1'b0), 1'b0);
        send_service(1'b0);
        send_byte(8'h5A, 1'b0);
        idle(1);
        checks++;
        if (bytes.size() != 2 || bytes[0] !== 8'hA5 || bytes[1] !== 8'h5A) begin
            failures++;
            $display("FAIL abort_bytes: got count=%0d want 2 bytes a5 5a", bytes.size());
        end
        checks++;
        if (n_last != 1 || last_byte !== 8'h5A || n_sig_vld != 2 || n_sig_err != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_last: got last=%0d byte=%h vld=%0d err=%0d busy=%b want 1 5a 2 0 0",
                     n_last, last_byte, n_sig_vld, n_sig_err, busy);
        end
    endtask

    task automatic test_gaps_reset();
        clear_mon();
        pulse_new_frame(1'b0);
        send_sig(mk_sig(4'b1011, 12'd3, 1'b0, 6'd0, 1'b0), 1'b1);
        send_service(1'b1);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(1);
        checks++;
        if (bytes.size() != 3 || bytes[0] !== 8'hA5 || bytes[1] !== 8'h3C || bytes[2] !== 8'hFF
            || n_last != 1 || last_byte !== 8'hFF) begin
            failures++;
            $display("FAIL gaps_bytes: got count=%0d last=%0d lastbyte=%h want 3 a5 3c ff, 1 ff",
                     bytes.size(), n_last, last_byte);
        end
        clear_mon();
        pulse_new_frame(1'b0);
        send_sig(mk_sig(4'b1011, 12'd3, 1'b0, 6'd0, 1'b0), 1'b1);
        send_service(1'b1);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, rand_gap());
        rst_n = 1'b0;
        idle(1);
        checks++;
        if ({sig_type, sig_len, sig_vld, sig_err, err_code, do_byte, do_vld, do_last, busy} !== 36'd0) begin
            failures++;
            $display("FAIL gaps_reset_outputs: got type=%h len=%h do=%h busy=%b want all 0",
                     sig_type, sig_len, do_byte, busy);
        end
        rst_n = 1'b1;
        clear_mon();
        send_sig(mk_sig(4'b1011, 12'd3, 1'b0, 6'd0, 1'b0), 1'b0);
        send_byte(8'hA5, 1'b0);
        idle(1);
        checks++;
        if (n_sig_vld != 0 || n_sig_err != 0 || bytes.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL gaps_reset_idle: got vld=%0d err=%0d bytes=%0d busy=%b want 0 0 0 0",
                     n_sig_vld, n_sig_err, bytes.size(), busy);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_valid();
        test_parity();
        test_reserved();
        test_rate_len();
        test_abort();
        test_gaps_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
